frequency_generator: RTL and testbench
======================================

Name: frequency_generator

Overview:
- Programmable square-wave source; the transmit-side counterpart of the edge-counting frequency counter.
- Takes a two-digit BCD target (tens, units) and emits exactly that many evenly spaced rising edges on `signal` per measurement frame.
- The frame length uses the same `period` convention as the counter: `update_period` + 1 clocks.
- Used as an on-chip stimulus and loopback source for the counter and its seven-segment display.

Parameters:
- UPDATE_PERIOD, 1199: reset value of `update_period`; frame length = `update_period` + 1 clocks.
- BITS, 12: width of `period`, the frame counter and the accumulator modulus.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- period  input  BITS  new frame period value.
- period_load  input  1  request to load `period`.
- ten_count  input  4  BCD tens digit of the target edge count.
- unit_count  input  4  BCD units digit of the target edge count.
- load  input  1  request to load `ten_count`/`unit_count`.
- signal  output  1  generated square wave.
- frame  output  1  one-clock strobe on the last clock of each frame.
- load_err  output  1  one-clock strobe when a digit load is rejected.
- active_ten  output  4  tens digit currently being generated.
- active_unit  output  4  units digit currently being generated.

Behaviour:
- Reset (async assert, sync release):
  - `update_period` = UPDATE_PERIOD.
  - Active and pending targets = 0; `frame_cnt` = 0; `acc` = 0.
  - `signal`, `frame`, `load_err` all 0.
  - Pending-valid flags cleared.
  - Outputs go to reset values immediately on assertion, including mid-frame.
- Target N = 10*ten + unit, computed in 8 bits; range 0..99.
- Digit load validation on `load`:
  - Reject if either digit > 9, or if 2N > `update_period` + 1, checked against the `update_period` in effect that clock.
  - On reject, `load_err` = 1 the next clock; pending state unchanged.
  - On accept, digits go into pending registers. The latest accepted load wins; earlier pending loads are overwritten.
- `period_load`: latch `period` into pending-period. Applied only at a frame boundary, never mid-frame.
- Frame counter:
  - `frame_cnt` counts 0..`update_period`.
  - When `frame_cnt` == `update_period`: `frame` = 1 that cycle, and at the clock edge `frame_cnt` goes to 0, `acc` goes to 0, and pending period/digits are committed to active.
  - If `period_load` or `load` coincides with the boundary cycle, the new value goes to pending and commits at the next boundary.
- Edge synthesis (Bresenham accumulator):
  - `acc` is BITS+1 bits; M = active `update_period` + 1.
  - Each clock, sum = `acc` + 2N.
    - If sum ≥ M: `acc` ← sum − M and `signal` toggles.
    - Else: `acc` ← sum.
  - Over M clocks there are exactly 2N toggles, the last on the final frame clock. `signal` is therefore 0 at every frame start, and there are exactly N rising edges per frame.
  - Constraint 2N ≤ M guarantees at most one toggle per clock.
- N = 0: `signal` held 0; `frame` still strobes.
- `period` = 0 (M = 1): only N = 0 is legal; `frame` strobes every clock.
- A committed period that is smaller than the active N's requirement (2N > M): force active N to 0 at that boundary and pulse `load_err`.
- No latency constraint on `active_ten`/`active_unit`: they change only at a boundary commit.
- `signal` is registered; there is no combinational path from any input to any output.

Test Plan:
- UPDATE_PERIOD=99, load tens=0 units=5 → after the next `frame`: `signal` high 10 / low 10 clocks, first rise on the 10th clock of the frame, 5 rises per 100-clock frame, `signal`=0 at each `frame`+1.
- UPDATE_PERIOD=99, load 5/0 (N=50) → `signal` toggles every clock, 50 rises per frame; then load 5/1 → `load_err` pulses once, output unchanged.
- Load tens=10 units=3 → `load_err` = 1 for one clock; `active_ten`/`active_unit` unchanged.
- Mid-frame `period_load` with `period`=49 while N=5 → current frame finishes at 100 clocks, next frames are 50 clocks with 5 rises (toggle every 5).
- Deassert `reset_n` mid-frame with N=7 → `signal`, `frame`, `load_err` go to 0 asynchronously; after release, `signal` stays 0 (N=0) and `frame` strobes every 1200 clocks.
- Loopback: connect `signal` to the frequency counter's `signal` input with equal periods, N=42 → once both are aligned to `frame`, the counter displays tens=4 units=2 every frame.

Source files
------------

// File: rtl/frequency_generator.sv
// Programmable square-wave source: emits N = 10*ten + unit evenly spaced rising
// edges per frame of update_period+1 clocks, using a Bresenham accumulator.
module frequency_generator #(
    parameter int UPDATE_PERIOD = 1199,
    parameter int BITS          = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
    input  logic [3:0]      ten_count,
    input  logic [3:0]      unit_count,
    input  logic            load,
    output logic            signal,
    output logic            frame,
    output logic            load_err,
    output logic [3:0]      active_ten,
    output logic [3:0]      active_unit
);

    // Arithmetic width wide enough for M = update_period + 1 and acc + 2N.
    localparam int MW = BITS + 2;

    function automatic logic [7:0] bcd_value(input logic [3:0] ten, input logic [3:0] unit);
        logic [7:0] t;
        t = {4'b0000, ten};
        return (t << 3) + (t << 1) + {4'b0000, unit};
    endfunction

    logic [BITS-1:0] r_update_period;
    logic [BITS-1:0] r_pend_period;
    logic            r_pend_period_vld;
    logic [3:0]      r_pend_ten;
    logic [3:0]      r_pend_unit;
    logic            r_pend_dig_vld;
    logic [3:0]      r_act_ten;
    logic [3:0]      r_act_unit;
    logic [BITS-1:0] r_frame_cnt;
    logic [BITS:0]   r_acc;
    logic            r_signal;
    logic            r_load_err;

    logic [MW-1:0]   w_modulus;
    logic            w_boundary;
    logic [7:0]      w_load_n;
    logic            w_load_bad;
    logic            w_load_ok;
    logic            w_load_rej;
    logic [BITS-1:0] w_commit_period;
    logic [3:0]      w_commit_ten;
    logic [3:0]      w_commit_unit;
    logic [7:0]      w_commit_n;
    logic            w_commit_bad;
    logic [7:0]      w_act_n;
    logic [MW-1:0]   w_sum;
    logic            w_wrap;
    logic [MW-1:0]   w_acc_next;

    assign w_modulus  = MW'(r_update_period) + MW'(1);
    assign w_boundary = (r_frame_cnt == r_update_period);

    // Digit loads are validated against the period in effect right now.
    assign w_load_n   = bcd_value(ten_count, unit_count);
    assign w_load_bad = (ten_count > 4'd9) || (unit_count > 4'd9) ||
                        (MW'({w_load_n, 1'b0}) > w_modulus);
    assign w_load_ok  = load && !w_load_bad;
    assign w_load_rej = load && w_load_bad;

    // Values that become active at the boundary; re-checked because a pending
    // period may be too short for the digits that will be in force with it.
    assign w_commit_period = r_pend_period_vld ? r_pend_period : r_update_period;
    assign w_commit_ten    = r_pend_dig_vld ? r_pend_ten  : r_act_ten;
    assign w_commit_unit   = r_pend_dig_vld ? r_pend_unit : r_act_unit;
    assign w_commit_n      = bcd_value(w_commit_ten, w_commit_unit);
    assign w_commit_bad    = MW'({w_commit_n, 1'b0}) > (MW'(w_commit_period) + MW'(1));

    assign w_act_n    = bcd_value(r_act_ten, r_act_unit);
    assign w_sum      = MW'(r_acc) + MW'({w_act_n, 1'b0});
    assign w_wrap     = (w_sum >= w_modulus);
    assign w_acc_next = w_wrap ? (w_sum - w_modulus) : w_sum;

    // Frame counter, accumulator and output toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_acc       <= '0;
            r_signal    <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_signal <= ~r_signal;
            end
            if (w_boundary) begin
                r_frame_cnt <= '0;
                r_acc       <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + BITS'(1);
                r_acc       <= w_acc_next[BITS:0];
            end
        end
    end

    // Pending registers: the latest accepted request wins, a request landing on
    // the boundary cycle stays pending for the following boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_period     <= '0;
            r_pend_period_vld <= 1'b0;
            r_pend_ten        <= '0;
            r_pend_unit       <= '0;
            r_pend_dig_vld    <= 1'b0;
        end else begin
            if (period_load) begin
                r_pend_period     <= period;
                r_pend_period_vld <= 1'b1;
            end else if (w_boundary) begin
                r_pend_period_vld <= 1'b0;
            end
            if (w_load_ok) begin
                r_pend_ten     <= ten_count;
                r_pend_unit    <= unit_count;
                r_pend_dig_vld <= 1'b1;
            end else if (w_boundary) begin
                r_pend_dig_vld <= 1'b0;
            end
        end
    end

    // Active settings and error strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_update_period <= BITS'(UPDATE_PERIOD);
            r_act_ten       <= '0;
            r_act_unit      <= '0;
            r_load_err      <= 1'b0;
        end else begin
            r_load_err <= w_load_rej || (w_boundary && w_commit_bad);
            if (w_boundary) begin
                r_update_period <= w_commit_period;
                if (w_commit_bad) begin
                    r_act_ten  <= '0;
                    r_act_unit <= '0;
                end else begin
                    r_act_ten  <= w_commit_ten;
                    r_act_unit <= w_commit_unit;
                end
            end
        end
    end

    assign signal      = r_signal;
    assign frame       = w_boundary;
    assign load_err    = r_load_err;
    assign active_ten  = r_act_ten;
    assign active_unit = r_act_unit;

endmodule

// File: tb/tb_frequency_generator.sv
// Scoreboard bench: stimulus queues one expected record per frame; a monitor
// measures each frame (length, rises, error pulses, active digits) and compares.
module tb_frequency_generator;

    localparam int BITS = 12;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [BITS-1:0] period;
    logic            period_load;
    logic [3:0]      ten_count;
    logic [3:0]      unit_count;
    logic            load;
    logic            signal;
    logic            frame;
    logic            load_err;
    logic [3:0]      active_ten;
    logic [3:0]      active_unit;

    frequency_generator #(.UPDATE_PERIOD(99), .BITS(BITS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .period      (period),
        .period_load (period_load),
        .ten_count   (ten_count),
        .unit_count  (unit_count),
        .load        (load),
        .signal      (signal),
        .frame       (frame),
        .load_err    (load_err),
        .active_ten  (active_ten),
        .active_unit (active_unit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rises;
        int len;
        int ten;
        int unit;
        int errs;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input int rises, input int len, input int ten, input int unit, input int errs);
        exp_t e;
        e.rises = rises; e.len = len; e.ten = ten; e.unit = unit; e.errs = errs;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        ten_count = t; unit_count = u; load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    task automatic do_period(input logic [BITS-1:0] p);
        period = p; period_load = 1'b1;
        @(posedge clk); #2;
        period_load = 1'b0;
    endtask

    // Wait for the frame strobe; optionally drive a digit load in the boundary cycle.
    task automatic sync_frame(input bit bl, input logic [3:0] t, input logic [3:0] u);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            got = frame;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got no frame, expected one within 500 clocks");
        end
        if (bl) begin
            ten_count = t; unit_count = u; load = 1'b1;
        end
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    // Monitor: one record popped and checked per frame strobe.
    initial begin
        int   rise_cnt;
        int   clk_cnt;
        int   err_cnt;
        logic prev_sig;
        logic after_frame;
        exp_t e;
        rise_cnt = 0; clk_cnt = 0; err_cnt = 0; prev_sig = 1'b0; after_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rise_cnt = 0; clk_cnt = 0; err_cnt = 0; prev_sig = 1'b0; after_frame = 1'b0;
            end else begin
                clk_cnt++;
                if (after_frame) chk("signal_at_frame_start", int'(signal), 0);
                if (signal && !prev_sig) rise_cnt++;
                prev_sig    = signal;
                if (load_err) err_cnt++;
                after_frame = frame;
                if (frame) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame_records", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_len", clk_cnt, e.len);
                        chk("rises", rise_cnt, e.rises);
                        chk("load_err_pulses", err_cnt, e.errs);
                        chk("active_ten", int'(active_ten), e.ten);
                        chk("active_unit", int'(active_unit), e.unit);
                        $display("frame: len=%0d rises=%0d errs=%0d active=%0d%0d",
                                 clk_cnt, rise_cnt, err_cnt, active_ten, active_unit);
                    end
                    rise_cnt = 0; clk_cnt = 0; err_cnt = 0;
                end
            end
        end
    end

    initial begin
        bit seen_high;
        reset_n = 1'b1; period = '0; period_load = 1'b0;
        ten_count = '0; unit_count = '0; load = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_signal", int'(signal), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_load_err", int'(load_err), 0);
        chk("rst_active_ten", int'(active_ten), 0);
        chk("rst_active_unit", int'(active_unit), 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // A: N=0 after reset, load 0/5
        push(0, 100, 0, 0, 0);
        idle(5);
        do_load(4'd0, 4'd5);
        sync_frame(1'b0, 4'd0, 4'd0);
        // B: N=5, load 5/0 (2N == M, accepted)
        push(5, 100, 0, 5, 0);
        do_load(4'd5, 4'd0);
        sync_frame(1'b0, 4'd0, 4'd0);
        // C: N=50, 5/1 rejected
        push(50, 100, 5, 0, 1);
        idle(10);
        do_load(4'd5, 4'd1);
        sync_frame(1'b0, 4'd0, 4'd0);
        // D: illegal digit 10/3 rejected, then 0/5 accepted
        push(50, 100, 5, 0, 1);
        do_load(4'd10, 4'd3);
        idle(3);
        do_load(4'd0, 4'd5);
        sync_frame(1'b0, 4'd0, 4'd0);
        // E: mid-frame period change to 49 must not shorten this frame
        push(5, 100, 0, 5, 0);
        idle(30);
        do_period(12'd49);
        sync_frame(1'b0, 4'd0, 4'd0);
        // F: M=50, N=5; load 2/5 (2N == M)
        push(5, 50, 0, 5, 0);
        do_load(4'd2, 4'd5);
        sync_frame(1'b0, 4'd0, 4'd0);
        // G: N=25 toggles every clock; 2/6 rejected; period 29 too short for N=25
        push(25, 50, 2, 5, 1);
        do_load(4'd2, 4'd6);
        do_period(12'd29);
        sync_frame(1'b0, 4'd0, 4'd0);
        // H: forced N=0 with one error pulse at the boundary; load 0/7
        push(0, 30, 0, 0, 1);
        do_load(4'd0, 4'd7);
        sync_frame(1'b0, 4'd0, 4'd0);
        // I: N=7, M=30
        push(7, 30, 0, 7, 0);
        sync_frame(1'b0, 4'd0, 4'd0);

        // J: asynchronous reset while signal is high
        seen_high = 1'b0;
        for (int i = 0; i < 40 && !seen_high; i++) begin
            @(negedge clk);
            seen_high = signal;
        end
        chk("pre_reset_signal_high", int'(seen_high), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_signal", int'(signal), 0);
        chk("async_rst_frame", int'(frame), 0);
        chk("async_rst_load_err", int'(load_err), 0);
        chk("async_rst_active_ten", int'(active_ten), 0);
        chk("async_rst_active_unit", int'(active_unit), 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // R1: back to reset period and N=0; load 0/3 on the boundary cycle
        push(0, 100, 0, 0, 0);
        sync_frame(1'b1, 4'd0, 4'd3);
        // R2: boundary load is only pending
        push(0, 100, 0, 0, 0);
        sync_frame(1'b0, 4'd0, 4'd0);
        // R3: now active
        push(3, 100, 0, 3, 0);
        sync_frame(1'b0, 4'd0, 4'd0);

        chk("records_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
